gigatron_ram_arbiter: RTL and testbench

Time-slot arbiter for the single 32K x 8 synchronous RAM. It shares the RAM between the Gigatron core and two secondary requesters: a video fetcher, which is read-only, and a host loader/debug port, which can read and write. It runs on the fast system clock, which is 4x the CPU rate. It generates the CPU clock-enable tick, so the core sees a private RAM with a fixed read/write timing.

---
 rtl/gigatron_ram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_gigatron_ram_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gigatron_ram_arbiter.sv
// -----------------------------------------------------------------------------
// gigatron_ram_arbiter
//
// Time-slot arbiter for the single synchronous 32K x 8 RAM. Runs on the fast
// system clock (4x the CPU rate) and divides each CPU cycle into four slots
// selected by a 2-bit phase counter:
//   phase 0 : CPU read of cpu_r_addr
//   phase 1 : CPU write if cpu_we, otherwise a free slot
//   phase 2 : free slot
//   phase 3 : free slot (cpu_tick high; the core advances at the end of it)
// Free slots go to the video fetcher (read-only) or the host port (read/write).
// The RAM returns data one cycle after it samples the address, so a small
// rd_owner register remembers who owns the read that is coming back.
//
// Optional feature macro: GIGATRON_ARB_RR_EN
//   defined   : video and host share free slots round-robin
//   undefined : fixed priority, video over host (host can starve)
//
// Ports:
//   clock, rst                 fast clock, synchronous active-high reset
//   cpu_tick                   CPU clock enable, high when phase == 3
//   cpu_r_addr/cpu_w_addr/cpu_wdata/cpu_we   core RAM interface
//   cpu_rdata                  registered CPU read data (valid from phase 2)
//   vid_req/vid_addr           video read request, held until vid_ack
//   vid_ack/vid_rvalid/vid_rdata   grant pulse, return pulse + data
//   host_req/host_we/host_addr/host_wdata   host request, held until host_ack
//   host_ack/host_rvalid/host_rdata  grant pulse, read return pulse + data
//   mem_addr/mem_wdata/mem_we  RAM request (combinational from slot owner)
//   mem_rdata                  RAM read data, one cycle after address sampled
// -----------------------------------------------------------------------------
module gigatron_ram_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              rst,
  output logic              cpu_tick,
  input  logic [ADDR_W-1:0] cpu_r_addr,
  input  logic [ADDR_W-1:0] cpu_w_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Owner of the read whose data arrives on mem_rdata in the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2,
    OWN_HOST = 2'd3
  } owner_e;

  logic [1:0]        phase;
  owner_e            rd_owner;
  owner_e            rd_owner_next;
  logic              free_slot;
  logic              vid_win;
  logic              host_win;
  logic [DATA_W-1:0] vid_rdata_q;
  logic [DATA_W-1:0] host_rdata_q;

  // Phase 1 is only free when the core is not writing this CPU cycle.
  assign free_slot = (phase == 2'd2) || (phase == 2'd3) ||
                     ((phase == 2'd1) && !cpu_we);

`ifdef GIGATRON_ARB_RR_EN
  // 1 = host was the most recent free-slot winner, 0 = video.
  logic last_winner;

  // On a tie the requester that was not served last wins; a lone requester
  // always wins.
  assign vid_win  = free_slot && vid_req && (!host_req || last_winner);
  assign host_win = free_slot && host_req && !vid_win;
`else
  assign vid_win  = free_slot && vid_req;
  assign host_win = free_slot && host_req && !vid_req;
`endif

  // Grants are suppressed in a reset cycle so nothing is acknowledged that
  // the reset is about to discard.
  assign vid_ack  = vid_win && !rst;
  assign host_ack = host_win && !rst;
  assign cpu_tick = (phase == 2'd3) && !rst;

  // Slot owner -> RAM request and read-return bookkeeping.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_we        = 1'b0;
    rd_owner_next = OWN_NONE;

    if (phase == 2'd0) begin
      mem_addr      = cpu_r_addr;
      rd_owner_next = OWN_CPU;
    end else if ((phase == 2'd1) && cpu_we) begin
      mem_addr  = cpu_w_addr;
      mem_wdata = cpu_wdata;
      mem_we    = 1'b1;
    end else if (vid_win) begin
      mem_addr      = vid_addr;
      rd_owner_next = OWN_VID;
    end else if (host_win) begin
      mem_addr = host_addr;
      if (host_we) begin
        mem_wdata = host_wdata;
        mem_we    = 1'b1;
      end else begin
        rd_owner_next = OWN_HOST;
      end
    end

    if (rst) begin
      mem_we = 1'b0;
    end
  end

  // Return data is presented combinationally in the return cycle so it lines
  // up with the rvalid pulse; the holding registers keep the last value.
  assign vid_rvalid  = (rd_owner == OWN_VID) && !rst;
  assign host_rvalid = (rd_owner == OWN_HOST) && !rst;
  assign vid_rdata   = vid_rvalid  ? mem_rdata : vid_rdata_q;
  assign host_rdata  = host_rvalid ? mem_rdata : host_rdata_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      phase        <= 2'd0;
      rd_owner     <= OWN_NONE;
      cpu_rdata    <= '0;
      vid_rdata_q  <= '0;
      host_rdata_q <= '0;
`ifdef GIGATRON_ARB_RR_EN
      // Start as if the host was served last so video wins the first tie.
      last_winner  <= 1'b1;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the values from before this edge.
      phase    <= phase + 2'd1;
      rd_owner <= rd_owner_next;

      case (rd_owner)
        OWN_CPU:  cpu_rdata    <= mem_rdata;
        OWN_VID:  vid_rdata_q  <= mem_rdata;
        OWN_HOST: host_rdata_q <= mem_rdata;
        default:  ;
      endcase

`ifdef GIGATRON_ARB_RR_EN
      if (vid_win) begin
        last_winner <= 1'b0;
      end else if (host_win) begin
        last_winner <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_gigatron_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gigatron_ram_arbiter
//
// Randomized bench for gigatron_ram_arbiter. A synchronous RAM model sits on
// the mem_* port. A reference model tracks the round position as
// cycle count mod 4, decides every slot from the arbitration rules, keeps a
// shadow copy of the RAM and a queue of pending read returns, and predicts
// every output cycle by cycle. Directed windows cover slot bandwidth,
// starvation/round-robin sharing and a reset in the middle of a host read.
// -----------------------------------------------------------------------------
module tb_gigatron_ram_arbiter;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;

  logic              clock = 1'b0;
  logic              rst;
  logic              cpu_tick;
  logic [ADDR_W-1:0] cpu_r_addr;
  logic [ADDR_W-1:0] cpu_w_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  gigatron_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock      (clock),
    .rst        (rst),
    .cpu_tick   (cpu_tick),
    .cpu_r_addr (cpu_r_addr),
    .cpu_w_addr (cpu_w_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_rdata  (cpu_rdata),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_ack    (vid_ack),
    .vid_rvalid (vid_rvalid),
    .vid_rdata  (vid_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous RAM: address sampled on the edge, data out the next cycle.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1] = '{default: 8'h00};
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  localparam int WHO_NONE = 0;
  localparam int WHO_CPU  = 1;
  localparam int WHO_VID  = 2;
  localparam int WHO_HOST = 3;

  typedef struct {
    int          who;
    logic [7:0]  data;
  } ret_t;

  logic [7:0] shadow [0:(1<<ADDR_W)-1];
  ret_t       ret_q[$];
  int         m_phase;
  logic [7:0] exp_cpu_rdata;
  logic [7:0] exp_vid_rdata;
  logic [7:0] exp_host_rdata;
  bit         m_last_host;
  bit         vid_got;
  bit         host_got;
  bit         last_host_read_ack;
  int         host_ack_seen;
  int         vid_ack_seen;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp,
               $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] pick_addr();
    logic [ADDR_W-1:0] a;
    case ($urandom_range(0, 5))
      0:       a = 15'h0000;
      1:       a = 15'h7FFF;
      2:       a = 15'h0100;
      3:       a = 15'h0200;
      default: a = 15'h0100 + 15'($urandom_range(0, 7));
    endcase
    return a;
  endfunction

  task automatic model_reset();
    m_phase        = 0;
    ret_q.delete();
    exp_cpu_rdata  = 8'h00;
    exp_vid_rdata  = 8'h00;
    exp_host_rdata = 8'h00;
    m_last_host    = 1'b1;
    vid_got        = 1'b0;
    host_got       = 1'b0;
  endtask

  // One system-clock cycle: drive inputs, predict, compare, advance model.
  // mode 0: random traffic; 1: video and host both held, cpu_we=0;
  // 2: host alone held, cpu_we=0.
  task automatic run_cycle(input int mode);
    bit          e_vack, e_hack, e_we, chk_wd, free, vid_wins;
    logic [14:0] e_addr;
    logic [7:0]  e_wd;
    ret_t        prev, nxt;

    @(posedge clock);
    #1;
    rst = 1'b0;

    // CPU inputs change only after the tick edge, stable across a round.
    if (m_phase == 0) begin
      cpu_r_addr = pick_addr();
      cpu_w_addr = pick_addr();
      cpu_wdata  = 8'($urandom);
      cpu_we     = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    if (mode == 2) begin
      vid_req = 1'b0;
    end else if (mode == 1) begin
      vid_req = 1'b1;
      if (vid_got) vid_addr = pick_addr();
    end else if (!vid_req || vid_got) begin
      vid_req  = ($urandom_range(0, 2) != 0);
      vid_addr = pick_addr();
    end

    if (mode != 0) begin
      host_req = 1'b1;
      if (host_got) begin
        host_addr  = pick_addr();
        host_we    = 1'($urandom_range(0, 1));
        host_wdata = 8'($urandom);
      end
    end else if (!host_req || host_got) begin
      host_req   = ($urandom_range(0, 2) != 0);
      host_addr  = pick_addr();
      host_we    = 1'($urandom_range(0, 1));
      host_wdata = 8'($urandom);
    end
    #1;

    // --- predict this cycle's slot ---
    e_vack = 0; e_hack = 0; e_we = 0; chk_wd = 1;
    e_addr = '0; e_wd = '0;
    nxt.who = WHO_NONE; nxt.data = 8'h00;
    free = (m_phase >= 2) || (m_phase == 1 && !cpu_we);
`ifdef GIGATRON_ARB_RR_EN
    vid_wins = vid_req && (!host_req || m_last_host);
`else
    vid_wins = vid_req;
`endif
    if (m_phase == 0) begin
      e_addr = cpu_r_addr; chk_wd = 0;
      nxt.who = WHO_CPU; nxt.data = shadow[cpu_r_addr];
    end else if (m_phase == 1 && cpu_we) begin
      e_addr = cpu_w_addr; e_wd = cpu_wdata; e_we = 1;
    end else if (free && vid_wins) begin
      e_vack = 1; e_addr = vid_addr; chk_wd = 0;
      nxt.who = WHO_VID; nxt.data = shadow[vid_addr];
    end else if (free && host_req) begin
      e_hack = 1; e_addr = host_addr;
      if (host_we) begin
        e_we = 1; e_wd = host_wdata;
      end else begin
        chk_wd = 0;
        nxt.who = WHO_HOST; nxt.data = shadow[host_addr];
      end
    end

    prev.who = WHO_NONE; prev.data = 8'h00;
    if (ret_q.size() > 0) prev = ret_q.pop_front();
    if (prev.who == WHO_VID)  exp_vid_rdata  = prev.data;
    if (prev.who == WHO_HOST) exp_host_rdata = prev.data;

    check("cpu_tick",    cpu_tick,    32'(m_phase == 3));
    check("vid_ack",     vid_ack,     32'(e_vack));
    check("host_ack",    host_ack,    32'(e_hack));
    check("mem_we",      mem_we,      32'(e_we));
    check("mem_addr",    mem_addr,    32'(e_addr));
    if (chk_wd) check("mem_wdata", mem_wdata, 32'(e_wd));
    check("vid_rvalid",  vid_rvalid,  32'(prev.who == WHO_VID));
    check("vid_rdata",   vid_rdata,   32'(exp_vid_rdata));
    check("host_rvalid", host_rvalid, 32'(prev.who == WHO_HOST));
    check("host_rdata",  host_rdata,  32'(exp_host_rdata));
    check("cpu_rdata",   cpu_rdata,   32'(exp_cpu_rdata));

    if (host_ack) host_ack_seen++;
    if (vid_ack)  vid_ack_seen++;

    // --- advance model to the next cycle ---
    if (e_we) shadow[e_addr] = e_wd;
    if (prev.who == WHO_CPU) exp_cpu_rdata = prev.data;
    if (nxt.who != WHO_NONE) ret_q.push_back(nxt);
    if (e_vack) m_last_host = 1'b0;
    if (e_hack) m_last_host = 1'b1;
    vid_got  = e_vack;
    host_got = e_hack;
    last_host_read_ack = e_hack && !host_we;
    m_phase  = (m_phase + 1) % 4;
  endtask

  // Bring the model to the last cycle of a round so the next cycle is phase 0.
  task automatic align_to_round();
    for (int i = 0; i < 8 && m_phase != 0; i++) run_cycle(0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit found;

    for (int i = 0; i < (1 << ADDR_W); i++) shadow[i] = 8'h00;
    rst = 1'b1;
    cpu_r_addr = '0; cpu_w_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
    vid_req = 1'b0; vid_addr = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    last_host_read_ack = 1'b0;
    host_ack_seen = 0;
    vid_ack_seen  = 0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_cpu_tick",  cpu_tick,  32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_mem_we",    mem_we,    32'd0);
    model_reset();

    // Randomized mixed traffic.
    for (int i = 0; i < 600; i++) run_cycle(0);

    // Host alone with no CPU writes: 3 grants per 4 cycles.
    align_to_round();
    host_ack_seen = 0;
    for (int i = 0; i < 8; i++) run_cycle(2);
    check("host_bw_8cyc", 32'(host_ack_seen), 32'd6);

    // Both secondaries held continuously.
    align_to_round();
    host_ack_seen = 0;
    vid_ack_seen  = 0;
    for (int i = 0; i < 12; i++) run_cycle(1);
    check("free_slots_12cyc", 32'(host_ack_seen + vid_ack_seen), 32'd9);
`ifdef GIGATRON_ARB_RR_EN
    check("rr_host_share", 32'(host_ack_seen == 4 || host_ack_seen == 5), 32'd1);
`else
    check("starve_host", 32'(host_ack_seen), 32'd0);
`endif

    // Reset the cycle after a host read grant: its return must vanish.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      run_cycle(0);
      found = last_host_read_ack;
    end
    check("host_read_found", 32'(found), 32'd1);
    @(posedge clock);
    #1;
    rst      = 1'b1;
    vid_req  = 1'b0;
    host_req = 1'b0;
    cpu_we   = 1'b0;
    #1;
    check("rstcyc_host_rvalid", host_rvalid, 32'd0);
    check("rstcyc_vid_rvalid",  vid_rvalid,  32'd0);
    check("rstcyc_host_ack",    host_ack,    32'd0);
    check("rstcyc_vid_ack",     vid_ack,     32'd0);
    check("rstcyc_mem_we",      mem_we,      32'd0);
    check("rstcyc_cpu_tick",    cpu_tick,    32'd0);
    model_reset();
    // First cycles after reset are checked against a phase-0 model with all
    // holding registers cleared.
    for (int i = 0; i < 200; i++) run_cycle(0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
